// File: rtl/osc_pkg.sv
// ---------------------------------------------------------------------------
// osc_pkg
// Shared types and constants for the sample frame scheduler.
//   frame_state_t : byte sequencer states (IDLE, header, three payload bytes)
//   SAMPLE_W      : payload width carried by one frame
//   FRAME_BYTES   : bytes per frame (header + three data bytes)
//   CH_ID_BIT     : header bit holding the channel id
// ---------------------------------------------------------------------------
package osc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        B0,
        B1,
        B2
    } frame_state_t;

    localparam int SAMPLE_W    = 24;
    localparam int FRAME_BYTES = 4;
    localparam int CH_ID_BIT   = 7;

endpackage

// File: rtl/channel_capture.sv
// ---------------------------------------------------------------------------
// channel_capture
// Per-channel front end: decimation counter, one-deep holding buffer and a
// sticky overflow flag.
// Ports:
//   clk, reset          : clock, asynchronous active-low reset
//   enable              : when low, incoming samples are ignored
//   decim               : keep 1 of every decim+1 accepted samples
//   sample_valid/data   : incoming sample strobe and value
//   grant               : the scheduler takes hold this cycle
//   clear_overflow      : synchronous clear of the overflow flag
//   pending, hold       : buffered sample waiting for a frame
//   overflow            : sticky flag, a passing sample was dropped
// ---------------------------------------------------------------------------
module channel_capture #(
    parameter int DATA_W  = 24,
    parameter int DECIM_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [DECIM_W-1:0] decim,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    input  logic              grant,
    input  logic              clear_overflow,
    output logic              pending,
    output logic [DATA_W-1:0] hold,
    output logic              overflow
);

    localparam logic [DECIM_W-1:0] COUNT_ONE = 1;

    logic [DECIM_W-1:0] count_q, count_d;
    logic               pending_q, pending_d;
    logic [DATA_W-1:0]  hold_q, hold_d;
    logic               overflow_q, overflow_d;
    logic               pass;
    logic               drop;

    always_comb begin
        count_d    = count_q;
        pending_d  = pending_q;
        hold_d     = hold_q;
        overflow_d = overflow_q;
        pass       = 1'b0;
        drop       = 1'b0;

        // The decimation counter only moves on accepted samples, so it
        // freezes while capture is disabled. A new decim is picked up on reload.
        if (enable && sample_valid) begin
            if (count_q == '0) begin
                pass    = 1'b1;
                count_d = decim;
            end else begin
                count_d = count_q - COUNT_ONE;
            end
        end

        if (grant) begin
            pending_d = 1'b0;
        end

        // A grant in the same cycle frees the slot: the old value leaves with
        // the frame and the new one takes its place without an overflow.
        if (pass) begin
            if (!pending_q || grant) begin
                hold_d    = sample_data;
                pending_d = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end

        // Setting has priority over a coincident clear.
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clear_overflow) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q    <= '0;
            pending_q  <= 1'b0;
            hold_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            pending_q  <= pending_d;
            hold_q     <= hold_d;
            overflow_q <= overflow_d;
        end
    end

    assign pending  = pending_q;
    assign hold     = hold_q;
    assign overflow = overflow_q;

endmodule

// File: rtl/sample_frame_scheduler.sv
// ---------------------------------------------------------------------------
// sample_frame_scheduler
// Captures decimated samples from two channels and sends them over a single
// flow-controlled byte path as 4-byte frames: header {ch, settings[6:0]},
// then the 24-bit sample LSB first. Channels are arbitrated round-robin.
// Ports:
//   clk, reset            : clock, asynchronous active-low reset
//   enable                : capture enable (frames in flight still drain)
//   settings              : bits [6:0] are copied into the header at grant
//   decim                 : per-channel decimation ratio (keep 1 of decim+1)
//   sample_valid/data     : per-channel sample strobes and values (flat)
//   byte_data/valid/ready : valid/ready byte stream to the transmitter
//   overflow              : sticky per-channel drop flags
//   clear_overflow        : synchronous clear of all overflow flags
//   busy                  : a frame is in progress
// ---------------------------------------------------------------------------
module sample_frame_scheduler #(
    parameter int DATA_W  = 24,
    parameter int NUM_CH  = 2,
    parameter int DECIM_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [7:0]               settings,
    input  logic [DECIM_W-1:0]       decim,
    input  logic [NUM_CH-1:0]        sample_valid,
    input  logic [NUM_CH*DATA_W-1:0] sample_data,
    output logic [7:0]               byte_data,
    output logic                     byte_valid,
    input  logic                     byte_ready,
    output logic [NUM_CH-1:0]        overflow,
    input  logic                     clear_overflow,
    output logic                     busy
);

    import osc_pkg::*;

    frame_state_t       state_q, state_d;
    logic               rr_last_q, rr_last_d;
    logic [7:0]         header_q, header_d;
    logic [DATA_W-1:0]  frame_data_q, frame_data_d;

    logic [NUM_CH-1:0]  pending;
    logic [DATA_W-1:0]  hold [NUM_CH];
    logic [NUM_CH-1:0]  grant;
    logic               grant_ch;
    logic               handshake;
    logic               unused_settings_msb;

    assign unused_settings_msb = settings[7];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        channel_capture #(
            .DATA_W (DATA_W),
            .DECIM_W(DECIM_W)
        ) u_capture (
            .clk           (clk),
            .reset         (reset),
            .enable        (enable),
            .decim         (decim),
            .sample_valid  (sample_valid[g]),
            .sample_data   (sample_data[g*DATA_W +: DATA_W]),
            .grant         (grant[g]),
            .clear_overflow(clear_overflow),
            .pending       (pending[g]),
            .hold          (hold[g]),
            .overflow      (overflow[g])
        );
    end

    // Round-robin: on a tie the channel that did not go last wins.
    always_comb begin
        if (pending[0] && pending[1]) begin
            grant_ch = ~rr_last_q;
        end else begin
            grant_ch = pending[1];
        end
    end

    assign grant      = (state_q == IDLE && (|pending)) ? (NUM_CH'(1) << grant_ch) : '0;
    assign byte_valid = (state_q != IDLE);
    assign busy       = (state_q != IDLE);
    assign handshake  = byte_valid && byte_ready;

    always_comb begin
        state_d      = state_q;
        rr_last_d    = rr_last_q;
        header_d     = header_q;
        frame_data_d = frame_data_q;

        case (state_q)
            IDLE: begin
                if (|pending) begin
                    state_d      = HDR;
                    rr_last_d    = grant_ch;
                    frame_data_d = hold[grant_ch];
                    header_d     = {grant_ch, settings[CH_ID_BIT-1:0]};
                end
            end
            HDR:     if (handshake) state_d = B0;
            B0:      if (handshake) state_d = B1;
            B1:      if (handshake) state_d = B2;
            B2:      if (handshake) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bytes come straight from registers captured at grant, so they stay
    // stable through a stall and ignore later input changes.
    always_comb begin
        case (state_q)
            HDR:     byte_data = header_q;
            B0:      byte_data = frame_data_q[7:0];
            B1:      byte_data = frame_data_q[15:8];
            B2:      byte_data = frame_data_q[23:16];
            default: byte_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            rr_last_q    <= 1'b1;
            header_q     <= 8'h00;
            frame_data_q <= '0;
        end else begin
            state_q      <= state_d;
            rr_last_q    <= rr_last_d;
            header_q     <= header_d;
            frame_data_q <= frame_data_d;
        end
    end

endmodule

// File: tb/tb_sample_frame_scheduler.sv
// ---------------------------------------------------------------------------
// tb_sample_frame_scheduler
// Directed self-checking bench for sample_frame_scheduler. Inputs are driven
// and outputs sampled 1 time unit after the rising clock edge.
// ---------------------------------------------------------------------------
module tb_sample_frame_scheduler;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [7:0]  settings;
    logic [7:0]  decim;
    logic [1:0]  sample_valid;
    logic [47:0] sample_data;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_ready;
    logic [1:0]  overflow;
    logic        clear_overflow;
    logic        busy;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    sample_frame_scheduler #(
        .DATA_W (24),
        .NUM_CH (2),
        .DECIM_W(8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .settings      (settings),
        .decim         (decim),
        .sample_valid  (sample_valid),
        .sample_data   (sample_data),
        .byte_data     (byte_data),
        .byte_valid    (byte_valid),
        .byte_ready    (byte_ready),
        .overflow      (overflow),
        .clear_overflow(clear_overflow),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset        = 1'b0;
        sample_valid = 2'b00;
        step();
        step();
        reset = 1'b1;
        step();
    endtask

    // Drives one strobe; returns just after the edge that captured it.
    task automatic strobe(input logic [1:0] v, input logic [23:0] d0, input logic [23:0] d1);
        sample_valid = v;
        sample_data  = {d1, d0};
        step();
        sample_valid = 2'b00;
    endtask

    task automatic get_byte(output logic [7:0] b, output bit ok);
        ok = 1'b0;
        b  = 8'h00;
        for (int i = 0; i < 50; i++) begin
            if (byte_valid && byte_ready) begin
                b  = byte_data;
                ok = 1'b1;
                step();
                break;
            end
            step();
        end
    endtask

    // Frame packed as {header, byte0, byte1, byte2}.
    task automatic get_frame(output logic [31:0] f);
        logic [7:0] b;
        bit         ok;
        f = 32'h0;
        for (int k = 0; k < 4; k++) begin
            get_byte(b, ok);
            if (!ok) begin
                f = 32'hDEAD_BEEF;
                return;
            end
            f = {f[23:0], b};
        end
    endtask

    task automatic test_reset();
        reset          = 1'b0;
        enable         = 1'b1;
        settings       = 8'h5A;
        decim          = 8'd0;
        sample_valid   = 2'b00;
        sample_data    = '0;
        byte_ready     = 1'b1;
        clear_overflow = 1'b0;
        step();
        step();
        vec_cnt++; if (byte_valid !== 1'b0) begin miss_cnt++; $display("FAIL rst_byte_valid got %b want 0", byte_valid); end
        vec_cnt++; if (byte_data !== 8'h00) begin miss_cnt++; $display("FAIL rst_byte_data got %h want 00", byte_data); end
        vec_cnt++; if (overflow !== 2'b00) begin miss_cnt++; $display("FAIL rst_overflow got %b want 00", overflow); end
        vec_cnt++; if (busy !== 1'b0) begin miss_cnt++; $display("FAIL rst_busy got %b want 0", busy); end
        reset = 1'b1;
        step();
    endtask

    task automatic test_single_frame();
        strobe(2'b01, 24'hABCDEF, 24'h000000);
        vec_cnt++; if (byte_valid !== 1'b0) begin miss_cnt++; $display("FAIL single_t0_valid got %b want 0", byte_valid); end
        step();
        vec_cnt++; if (byte_valid !== 1'b1 || byte_data !== 8'h5A) begin miss_cnt++; $display("FAIL single_hdr got %b/%h want 1/5a", byte_valid, byte_data); end
        vec_cnt++; if (busy !== 1'b1) begin miss_cnt++; $display("FAIL single_busy got %b want 1", busy); end
        step();
        vec_cnt++; if (byte_data !== 8'hEF) begin miss_cnt++; $display("FAIL single_b0 got %h want ef", byte_data); end
        step();
        vec_cnt++; if (byte_data !== 8'hCD) begin miss_cnt++; $display("FAIL single_b1 got %h want cd", byte_data); end
        step();
        vec_cnt++; if (byte_data !== 8'hAB) begin miss_cnt++; $display("FAIL single_b2 got %h want ab", byte_data); end
        step();
        vec_cnt++; if (byte_valid !== 1'b0 || busy !== 1'b0) begin miss_cnt++; $display("FAIL single_end got %b/%b want 0/0", byte_valid, busy); end
    endtask

    task automatic test_round_robin();
        logic [31:0] f;
        do_reset();
        strobe(2'b11, 24'h000001, 24'h000002);
        get_frame(f);
        vec_cnt++; if (f !== 32'h5A010000) begin miss_cnt++; $display("FAIL rr_first got %h want 5a010000", f); end
        get_frame(f);
        vec_cnt++; if (f !== 32'hDA020000) begin miss_cnt++; $display("FAIL rr_second got %h want da020000", f); end
        // A lone ch0 frame leaves ch0 as last winner, so the next tie goes to ch1.
        strobe(2'b01, 24'h000003, 24'h000000);
        get_frame(f);
        vec_cnt++; if (f !== 32'h5A030000) begin miss_cnt++; $display("FAIL rr_single got %h want 5a030000", f); end
        strobe(2'b11, 24'h000004, 24'h000005);
        get_frame(f);
        vec_cnt++; if (f !== 32'hDA050000) begin miss_cnt++; $display("FAIL rr_alt_first got %h want da050000", f); end
        get_frame(f);
        vec_cnt++; if (f !== 32'h5A040000) begin miss_cnt++; $display("FAIL rr_alt_second got %h want 5a040000", f); end
    endtask

    task automatic test_decimation();
        logic [31:0] f;
        decim      = 8'd3;
        byte_ready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            strobe(2'b01, 24'hC00000 | 24'(i), 24'h000000);
        end
        byte_ready = 1'b1;
        get_frame(f);
        vec_cnt++; if (f !== 32'h5A0100C0) begin miss_cnt++; $display("FAIL decim_frame1 got %h want 5a0100c0", f); end
        get_frame(f);
        vec_cnt++; if (f !== 32'h5A0500C0) begin miss_cnt++; $display("FAIL decim_frame2 got %h want 5a0500c0", f); end
        for (int i = 0; i < 10; i++) step();
        vec_cnt++; if (byte_valid !== 1'b0) begin miss_cnt++; $display("FAIL decim_no_third got %b want 0", byte_valid); end
        vec_cnt++; if (overflow !== 2'b00) begin miss_cnt++; $display("FAIL decim_overflow got %b want 00", overflow); end
        decim = 8'd0;
    endtask

    task automatic test_stall();
        logic [7:0] b;
        bit         ok;
        strobe(2'b01, 24'h123456, 24'h000000);
        get_byte(b, ok);
        vec_cnt++; if (!ok || b !== 8'h5A) begin miss_cnt++; $display("FAIL stall_hdr got %h want 5a", b); end
        get_byte(b, ok);
        vec_cnt++; if (!ok || b !== 8'h56) begin miss_cnt++; $display("FAIL stall_b0 got %h want 56", b); end
        byte_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            vec_cnt++; if (byte_valid !== 1'b1 || byte_data !== 8'h34) begin miss_cnt++; $display("FAIL stall_hold got %b/%h want 1/34", byte_valid, byte_data); end
            step();
        end
        byte_ready = 1'b1;
        get_byte(b, ok);
        vec_cnt++; if (!ok || b !== 8'h34) begin miss_cnt++; $display("FAIL stall_b1 got %h want 34", b); end
        get_byte(b, ok);
        vec_cnt++; if (!ok || b !== 8'h12) begin miss_cnt++; $display("FAIL stall_b2 got %h want 12", b); end
        vec_cnt++; if (byte_valid !== 1'b0) begin miss_cnt++; $display("FAIL stall_end got %b want 0", byte_valid); end
    endtask

    task automatic test_overflow();
        logic [31:0] f;
        byte_ready = 1'b0;
        strobe(2'b01, 24'h0000A1, 24'h000000);
        step();
        strobe(2'b01, 24'h0000A2, 24'h000000);
        vec_cnt++; if (overflow !== 2'b00) begin miss_cnt++; $display("FAIL ovf_second got %b want 00", overflow); end
        strobe(2'b01, 24'h0000A3, 24'h000000);
        vec_cnt++; if (overflow !== 2'b01) begin miss_cnt++; $display("FAIL ovf_set got %b want 01", overflow); end
        clear_overflow = 1'b1;
        step();
        clear_overflow = 1'b0;
        vec_cnt++; if (overflow !== 2'b00) begin miss_cnt++; $display("FAIL ovf_clear got %b want 00", overflow); end
        clear_overflow = 1'b1;
        strobe(2'b01, 24'h0000A4, 24'h000000);
        clear_overflow = 1'b0;
        vec_cnt++; if (overflow !== 2'b01) begin miss_cnt++; $display("FAIL ovf_set_wins got %b want 01", overflow); end
        byte_ready = 1'b1;
        get_frame(f);
        vec_cnt++; if (f !== 32'h5AA10000) begin miss_cnt++; $display("FAIL ovf_frame1 got %h want 5aa10000", f); end
        get_frame(f);
        vec_cnt++; if (f !== 32'h5AA20000) begin miss_cnt++; $display("FAIL ovf_frame2 got %h want 5aa20000", f); end
        for (int i = 0; i < 6; i++) step();
        vec_cnt++; if (byte_valid !== 1'b0) begin miss_cnt++; $display("FAIL ovf_drained got %b want 0", byte_valid); end
        clear_overflow = 1'b1;
        step();
        clear_overflow = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] f;
        // ch0 went last, so ch1 wins the tie; ch0 stays pending.
        strobe(2'b11, 24'h111111, 24'h222222);
        step();
        vec_cnt++; if (byte_data !== 8'hDA) begin miss_cnt++; $display("FAIL mid_hdr got %h want da", byte_data); end
        step();
        vec_cnt++; if (byte_valid !== 1'b1 || byte_data !== 8'h22) begin miss_cnt++; $display("FAIL mid_b0 got %b/%h want 1/22", byte_valid, byte_data); end
        #2;
        reset = 1'b0;
        #1;
        vec_cnt++; if (byte_valid !== 1'b0 || busy !== 1'b0) begin miss_cnt++; $display("FAIL mid_async got %b/%b want 0/0", byte_valid, busy); end
        step();
        reset = 1'b1;
        for (int i = 0; i < 5; i++) step();
        vec_cnt++; if (byte_valid !== 1'b0) begin miss_cnt++; $display("FAIL mid_pending_cleared got %b want 0", byte_valid); end
        strobe(2'b10, 24'h000000, 24'h334455);
        step();
        vec_cnt++; if (byte_valid !== 1'b1 || byte_data !== 8'hDA) begin miss_cnt++; $display("FAIL mid_new_hdr got %b/%h want 1/da", byte_valid, byte_data); end
        get_frame(f);
        vec_cnt++; if (f !== 32'hDA554433) begin miss_cnt++; $display("FAIL mid_new_frame got %h want da554433", f); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_round_robin();
        test_decimation();
        test_stall();
        test_overflow();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
